bip_fetch_control: RTL and testbench
====================================

Name: bip_fetch_control

Overview:
- Instruction-side consumer of the BIP program memory. Owns the PC and drives the 11-bit fetch address.
- Accounts for the memory's one-cycle registered read latency, latches the 16-bit instruction and decodes opcode[15:11] into datapath controls.
- Operand[10:0] is forwarded to the datapath. HLT stops the processor.

Parameters:
- PC_W, 11, program address width; the PC wraps modulo 2^PC_W.
- INSTR_W, 16, instruction width; opcode is the top 5 bits, operand is the low PC_W bits.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- EN  in  1  run enable; sampled only in FETCH.
- INSTR  in  16  program memory DATA; valid the cycle after ADDR is presented.
- ADDR  out  11  program memory address; equals PC.
- OPERAND  out  11  IR[10:0]; immediate or data-memory address.
- WR_RAM  out  1  data memory write strobe.
- RD_RAM  out  1  data memory read enable.
- SEL_A  out  2  accumulator source: 00 = memory, 01 = immediate, 10 = ALU.
- SEL_B  out  1  ALU B operand: 0 = memory, 1 = immediate.
- OP_SUB  out  1  ALU function: 0 = add, 1 = subtract.
- WR_ACC  out  1  accumulator write enable.
- HALTED  out  1  high while in HALT.

Behaviour:
- Reset (asynchronous, RESET_N = 0):
  - PC = 0, IR = 0, state = FETCH.
  - All control outputs 0, HALTED = 0, ADDR = 0.
  - Reset asserted mid-instruction aborts that instruction; no strobe is emitted.
- States: FETCH -> DECODE -> EXEC -> FETCH, plus HALT.
- FETCH:
  - ADDR = PC.
  - EN = 1 -> DECODE. EN = 0 -> stay in FETCH, PC unchanged.
- DECODE: INSTR is valid this cycle; IR <= INSTR at the clock edge; -> EXEC.
- EXEC:
  - Controls are decoded from IR and asserted for exactly this one cycle.
  - PC <= PC + 1 (2047 wraps to 0); -> FETCH.
- HLT in EXEC:
  - No strobes asserted, PC not incremented; -> HALT.
- HALT:
  - HALTED = 1; PC and IR held; all strobes 0.
  - Exit only through reset; EN is ignored.
- Latency: 3 cycles per instruction. The first EXEC occurs in cycle 3 after reset release when EN = 1.
- Control outputs are 0 in every state except EXEC. OPERAND always reflects IR.
- Opcode decode:
  - 00000 HLT.
  - 00001 STO: WR_RAM.
  - 00010 LD: RD_RAM, SEL_A = 00, WR_ACC.
  - 00011 LDI: SEL_A = 01, WR_ACC.
  - 00100 ADD: RD_RAM, SEL_A = 10, SEL_B = 0, OP_SUB = 0, WR_ACC.
  - 00101 ADDI: SEL_A = 10, SEL_B = 1, OP_SUB = 0, WR_ACC.
  - 00110 SUB: as ADD with OP_SUB = 1.
  - 00111 SUBI: as ADDI with OP_SUB = 1.
  - 01000-11111 undefined: see Optional Feature.
- Outputs are glitch-free: decode is combinational from registered IR and state only.

Optional Feature:
- Macro: BIP_ILLEGAL_OPCODE_TRAP_EN.
- Defined:
  - An undefined opcode in EXEC behaves as HLT and goes to HALT.
  - Adds output ILLEGAL (1 bit, reset 0), which is set in the same transition and held until reset.
- Undefined: an undefined opcode executes as a NOP (no strobes, PC increments, -> FETCH). No ILLEGAL port exists.

Decomposition:
- Shared package bip_pkg holds:
  - opcode localparams (OP_HLT ... OP_SUBI);
  - the PC_W/INSTR_W defaults;
  - SEL_A encodings (SELA_MEM, SELA_IMM, SELA_ALU);
  - the state encoding (ST_FETCH, ST_DECODE, ST_EXEC, ST_HALT).
- Sub-module bip_instr_decoder: purely combinational, opcode[4:0] -> {WR_RAM, RD_RAM, SEL_A, SEL_B, OP_SUB, WR_ACC, is_hlt, is_illegal}. It is gated by EXEC in the parent.

Test Plan:
- Reset and halt:
  - Stimulus: RESET_N low for 2 cycles, then high, EN = 1, program memory holds STO 1 (0x0801) at address 0 and HLT at address 1.
  - Response: ADDR = 0 for cycles 1-3; WR_RAM = 1 with OPERAND = 1 in cycle 3 only; ADDR = 1 in cycle 4; HALTED = 1 from cycle 7 with ADDR still 1.
- Immediate arithmetic:
  - Stimulus: program LDI 0, ADDI 4, SUBI 2.
  - Response:
    - LDI 0 EXEC: WR_ACC = 1, SEL_A = 01, OPERAND = 0.
    - ADDI 4 EXEC: WR_ACC = 1, SEL_A = 10, SEL_B = 1, OP_SUB = 0, OPERAND = 4.
    - SUBI 2 EXEC: same as ADDI with OP_SUB = 1, OPERAND = 2.
  - Each EXEC is 3 cycles apart.
- Stall:
  - Stimulus: EN = 0 for 5 cycles while in FETCH at PC = 3.
  - Response: ADDR stays 3; no strobes; execution resumes 3 cycles after EN returns to 1.
- Wrap-around:
  - Stimulus: preload PC path to 2047 holding ADDI 1.
  - Response: after its EXEC, ADDR = 0.
- Reset mid-operation:
  - Stimulus: assert RESET_N low during the DECODE of STO 5.
  - Response: WR_RAM never pulses; PC = 0; state = FETCH.
- Illegal opcode:
  - Stimulus: opcode 0x1F at PC = 0.
  - Response with trap enabled: ILLEGAL = 1, HALTED = 1, PC stays 0.
  - Response with trap disabled: no strobes, PC = 1.

Source files
------------

// File: rtl/bip_pkg.sv
// bip_pkg: definitions shared by the BIP fetch/control slice.
//   - default program address and instruction widths
//   - 5-bit opcode values (OP_HLT .. OP_SUBI)
//   - accumulator source select encodings (SELA_*)
//   - fetch/control state encoding (ST_*)
package bip_pkg;

  localparam int unsigned BIP_PC_W    = 11;
  localparam int unsigned BIP_INSTR_W = 16;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALT   = 2'b11
  } state_t;

endpackage

// File: rtl/bip_instr_decoder.sv
// bip_instr_decoder: purely combinational opcode decoder.
//   opcode      in  5  instruction opcode (IR[15:11])
//   wr_ram      out 1  data memory write strobe
//   rd_ram      out 1  data memory read enable
//   sel_a       out 2  accumulator source select
//   sel_b       out 1  ALU B operand select (1 = immediate)
//   op_sub      out 1  ALU subtract
//   wr_acc      out 1  accumulator write enable
//   is_hlt      out 1  opcode is HLT
//   is_illegal  out 1  opcode is outside the defined set
// Outputs are not qualified by state; the parent gates them with EXEC.
module bip_instr_decoder
  import bip_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       wr_ram,
  output logic       rd_ram,
  output logic [1:0] sel_a,
  output logic       sel_b,
  output logic       op_sub,
  output logic       wr_acc,
  output logic       is_hlt,
  output logic       is_illegal
);

  always_comb begin
    wr_ram     = 1'b0;
    rd_ram     = 1'b0;
    sel_a      = SELA_MEM;
    sel_b      = 1'b0;
    op_sub     = 1'b0;
    wr_acc     = 1'b0;
    is_hlt     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_HLT:  is_hlt = 1'b1;
      OP_STO:  wr_ram = 1'b1;
      OP_LD: begin
        rd_ram = 1'b1;
        sel_a  = SELA_MEM;
        wr_acc = 1'b1;
      end
      OP_LDI: begin
        sel_a  = SELA_IMM;
        wr_acc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        rd_ram = 1'b1;
        sel_a  = SELA_ALU;
        sel_b  = 1'b0;
        op_sub = (opcode == OP_SUB);
        wr_acc = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        sel_a  = SELA_ALU;
        sel_b  = 1'b1;
        op_sub = (opcode == OP_SUBI);
        wr_acc = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_fetch_control.sv
// bip_fetch_control: BIP instruction fetch, PC ownership and control decode.
// Each instruction takes FETCH -> DECODE -> EXEC; HLT parks the FSM in HALT
// until reset.
//   CLK      in  1        system clock, rising edge
//   RESET_N  in  1        asynchronous active-low reset
//   EN       in  1        run enable, sampled in FETCH only
//   INSTR    in  INSTR_W  program memory data (one-cycle read latency)
//   ADDR     out PC_W     program memory address (= PC)
//   OPERAND  out PC_W     IR[PC_W-1:0]
//   WR_RAM, RD_RAM, SEL_A, SEL_B, OP_SUB, WR_ACC
//            out          datapath controls, active in EXEC only
//   HALTED   out 1        high while in HALT
//   ILLEGAL  out 1        sticky undefined-opcode trap flag
//                         (only with BIP_ILLEGAL_OPCODE_TRAP_EN)
// Build option: define BIP_ILLEGAL_OPCODE_TRAP_EN to halt on undefined
// opcodes and expose ILLEGAL; otherwise undefined opcodes execute as NOPs.
module bip_fetch_control
  import bip_pkg::*;
#(
  parameter int unsigned PC_W    = BIP_PC_W,
  parameter int unsigned INSTR_W = BIP_INSTR_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               EN,
  input  logic [INSTR_W-1:0] INSTR,
  output logic [PC_W-1:0]    ADDR,
  output logic [PC_W-1:0]    OPERAND,
  output logic               WR_RAM,
  output logic               RD_RAM,
  output logic [1:0]         SEL_A,
  output logic               SEL_B,
  output logic               OP_SUB,
  output logic               WR_ACC,
`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
  output logic               ILLEGAL,
`endif
  output logic               HALTED
);

`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
  localparam bit TRAP_ILLEGAL = 1'b1;
`else
  localparam bit TRAP_ILLEGAL = 1'b0;
`endif

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;

  logic       dec_wr_ram;
  logic       dec_rd_ram;
  logic [1:0] dec_sel_a;
  logic       dec_sel_b;
  logic       dec_op_sub;
  logic       dec_wr_acc;
  logic       dec_is_hlt;
  logic       dec_is_illegal;
  logic       exec;
  logic       stop;

  bip_instr_decoder u_decoder (
    .opcode     (ir[INSTR_W-1 -: 5]),
    .wr_ram     (dec_wr_ram),
    .rd_ram     (dec_rd_ram),
    .sel_a      (dec_sel_a),
    .sel_b      (dec_sel_b),
    .op_sub     (dec_op_sub),
    .wr_acc     (dec_wr_acc),
    .is_hlt     (dec_is_hlt),
    .is_illegal (dec_is_illegal)
  );

  // Undefined opcodes decode to no strobes, so with the trap disabled they
  // fall through the normal increment path as NOPs.
  assign stop = dec_is_hlt | (TRAP_ILLEGAL & dec_is_illegal);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (EN) state <= ST_DECODE;
        end
        ST_DECODE: begin
          ir    <= INSTR;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (stop) begin
            state <= ST_HALT;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= ST_FETCH;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ILLEGAL <= 1'b0;
    end else if (state == ST_EXEC && dec_is_illegal) begin
      ILLEGAL <= 1'b1;
    end
  end
`endif

  // Controls depend only on registered state and IR, so they cannot glitch.
  assign exec    = (state == ST_EXEC) && !stop;
  assign WR_RAM  = exec & dec_wr_ram;
  assign RD_RAM  = exec & dec_rd_ram;
  assign SEL_A   = exec ? dec_sel_a : '0;
  assign SEL_B   = exec & dec_sel_b;
  assign OP_SUB  = exec & dec_op_sub;
  assign WR_ACC  = exec & dec_wr_acc;
  assign HALTED  = (state == ST_HALT);
  assign ADDR    = pc;
  assign OPERAND = ir[PC_W-1:0];

endmodule

// File: tb/tb_bip_fetch_control.sv
// tb_bip_fetch_control: directed and randomized checks of bip_fetch_control
// against an instruction-level reference model with a registered program
// memory.
module tb_bip_fetch_control;

`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] instr = '0;
  logic [10:0] addr;
  logic [10:0] operand;
  logic        wr_ram, rd_ram, sel_b, op_sub, wr_acc, halted;
  logic [1:0]  sel_a;
`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
  logic        illegal;
`endif

  logic [15:0] mem [0:2047];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int exp_pc;
  int exp_op;
  bit exp_halt;
  bit exp_ill;
  bit stopped;

  bip_fetch_control #(.PC_W(11), .INSTR_W(16)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .EN      (en),
    .INSTR   (instr),
    .ADDR    (addr),
    .OPERAND (operand),
    .WR_RAM  (wr_ram),
    .RD_RAM  (rd_ram),
    .SEL_A   (sel_a),
    .SEL_B   (sel_b),
    .OP_SUB  (op_sub),
    .WR_ACC  (wr_acc),
`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
    .ILLEGAL (illegal),
`endif
    .HALTED  (halted)
  );

  always #5 clk = ~clk;

  // Program memory with one-cycle registered read
  always @(posedge clk) instr <= mem[addr];

  // Expected {WR_RAM, RD_RAM, SEL_A[1:0], SEL_B, OP_SUB, WR_ACC} per opcode
  function automatic logic [6:0] exp_ctrl(input logic [4:0] op);
    case (op)
      5'd1:    return 7'b1_0_00_0_0_0; // STO
      5'd2:    return 7'b0_1_00_0_0_1; // LD
      5'd3:    return 7'b0_0_01_0_0_1; // LDI
      5'd4:    return 7'b0_1_10_0_0_1; // ADD
      5'd5:    return 7'b0_0_10_1_0_1; // ADDI
      5'd6:    return 7'b0_1_10_0_1_1; // SUB
      5'd7:    return 7'b0_0_10_1_1_1; // SUBI
      default: return 7'b0;            // HLT / undefined
    endcase
  endfunction

  function automatic logic [31:0] ctrl_obs();
    return 32'({wr_ram, rd_ram, sel_a, sel_b, op_sub, wr_acc});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every non-EXEC cycle: no strobes, ADDR = PC, OPERAND = IR operand
  task automatic check_idle(input string tag);
    chk({tag, ".ctrl"},    ctrl_obs(), 32'd0);
    chk({tag, ".addr"},    32'(addr), 32'(exp_pc));
    chk({tag, ".operand"}, 32'(operand), 32'(exp_op));
    chk({tag, ".halted"},  32'(halted), 32'(exp_halt));
`ifdef BIP_ILLEGAL_OPCODE_TRAP_EN
    chk({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    exp_pc = 0; exp_op = 0; exp_halt = 1'b0; exp_ill = 1'b0;
    #1;
    check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one instruction from the current FETCH cycle; stall = cycles of EN=0.
  task automatic run_instr(input int stall, output bit halt_out);
    logic [15:0] cur;
    logic [4:0]  op;
    bit          hlt;
    check_idle("fetch");
    for (int i = 0; i < stall; i++) begin
      en = 1'b0;
      tick();
      check_idle("stall");
    end
    en = 1'b1;
    tick();
    check_idle("decode");
    en = 1'($urandom);
    tick();
    cur    = mem[exp_pc];
    op     = cur[15:11];
    exp_op = int'(cur[10:0]);
    hlt    = (op == 5'd0) || (TRAP && op > 5'd7);
    chk("exec.ctrl",    ctrl_obs(), 32'(exp_ctrl(op)));
    chk("exec.addr",    32'(addr), 32'(exp_pc));
    chk("exec.operand", 32'(operand), 32'(exp_op));
    chk("exec.halted",  32'(halted), 32'd0);
    en = 1'($urandom);
    tick();
    if (hlt) begin
      exp_halt = 1'b1;
      if (op != 5'd0) exp_ill = 1'b1;
      check_idle("halt");
    end else begin
      exp_pc = (exp_pc + 1) % 2048;
    end
    halt_out = hlt;
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 16'h0000;

    // Reset and halt: STO 1, HLT
    mem[0] = 16'h0801;
    mem[1] = 16'h0000;
    do_reset();
    run_instr(0, stopped);
    chk("rh.sto_not_halt", 32'(stopped), 32'd0);
    run_instr(0, stopped);
    chk("rh.hlt_halts", 32'(stopped), 32'd1);
    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom);
      tick();
      check_idle("rh.held");
    end

    // Immediate arithmetic, then a 5-cycle stall at PC 3
    mem[0] = 16'h1800; // LDI 0
    mem[1] = 16'h2804; // ADDI 4
    mem[2] = 16'h3802; // SUBI 2
    mem[3] = 16'h1007; // LD 7
    mem[4] = 16'h0000; // HLT
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, stopped);
    chk("imm.pc3", 32'(addr), 32'd3);
    run_instr(5, stopped);
    run_instr(0, stopped);
    chk("imm.halted", 32'(halted), 32'd1);

    // Reset during DECODE of STO 5 aborts it
    mem[0] = 16'h0805;
    mem[1] = 16'h0000;
    do_reset();
    en = 1'b1;
    tick();
    check_idle("mid.decode");
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid.async");
    tick();
    check_idle("mid.held");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    check_idle("mid.release");
    tick();
    check_idle("mid.fetch");
    run_instr(0, stopped);
    run_instr(0, stopped);

    // Undefined opcode 0x1F at PC 0
    mem[0] = {5'h1F, 11'($urandom)};
    mem[1] = 16'h0000;
    do_reset();
    run_instr(0, stopped);
    if (!stopped) begin
      chk("ill.nop_pc", 32'(addr), 32'd1);
      run_instr(0, stopped);
    end else begin
      chk("ill.pc_held", 32'(addr), 32'd0);
    end

    // Random legal program over the whole address space, ADDI 1 at 2047
    for (int a = 0; a < 2048; a++)
      mem[a] = {5'($urandom_range(1, 7)), 11'($urandom)};
    mem[2047] = 16'h2801;
    do_reset();
    for (int n = 0; n < 2048; n++) begin
      run_instr(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, stopped);
    end
    chk("wrap.addr0", 32'(addr), 32'd0);
    check_idle("wrap.fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
